keypad_scanner4x4: RTL and testbench

Scans a 4x4 hex key matrix and turns debounced presses into 4-bit key codes and a 16-bit entered value. It is the input-side counterpart of the 4-digit seven-segment display driver. It drives one-cold column lines at the same multiplexing cadence the display uses for its digit selects, and reads back the active-low row lines. The `value` output is shaped so the top level can feed it straight into the display driver.

---
 rtl/keypad_scanner4x4.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scanner4x4.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner4x4.sv
// 4x4 hex keypad scanner: one-cold column drive, synchronised active-low rows,
// full-scan debounce FSM, and a 16-bit shift register of accepted key codes.
module keypad_scanner4x4 #(
  parameter int SCAN_DIV_BITS  = 13,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int CW = SCAN_DIV_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_t;

  logic [3:0]    r_rowMeta;
  logic [3:0]    r_rowSync;
  logic [CW-1:0] r_scanCnt;
  logic [15:0]   r_lowMap;
  state_t        r_state;
  state_t        w_stateNext;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cntNext;
  logic [3:0]    w_cntInc;
  logic [3:0]    r_cand;
  logic [3:0]    w_candNext;
  logic          w_accept;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;
  logic [15:0]   r_value;
  logic [1:0]    w_colIdx;
  logic          w_sample;
  logic          w_eval;
  logic [15:0]   w_fullMap;
  scan_t         w_scan;
  logic [3:0]    w_scanKey;

  assign w_colIdx = r_scanCnt[CW-1 -: 2];
  assign w_sample = &r_scanCnt[SCAN_DIV_BITS-1:0];
  assign w_eval   = w_sample && (w_colIdx == 2'd3);
  assign col      = ~(4'b0001 << w_colIdx);
  assign w_cntInc = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
      r_scanCnt <= '0;
    end else begin
      r_rowMeta <= row;
      r_rowSync <= r_rowMeta;
      r_scanCnt <= r_scanCnt + 1'b1;
    end
  end

  // Map bit index is the key code {row, col}; the current column's low rows are merged in.
  always_comb begin
    w_fullMap = r_lowMap;
    for (int r = 0; r < 4; r++) begin
      if (!r_rowSync[r]) w_fullMap[{2'(r), w_colIdx}] = 1'b1;
    end
  end

  always_comb begin
    w_scan    = SCAN_NONE;
    w_scanKey = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_fullMap[i]) begin
        if (w_scan == SCAN_NONE) begin
          w_scan    = SCAN_SINGLE;
          w_scanKey = 4'(i);
        end else begin
          w_scan = SCAN_MULTI;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowMap <= '0;
    end else if (w_sample) begin
      r_lowMap <= (w_colIdx == 2'd3) ? 16'h0000 : w_fullMap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_cand  <= w_candNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_candNext  = r_cand;
    w_accept    = 1'b0;
    if (w_eval) begin
      case (r_state)
        ST_IDLE: begin
          if (w_scan == SCAN_SINGLE) begin
            w_stateNext = ST_DEBOUNCE;
            w_candNext  = w_scanKey;
            w_cntNext   = 4'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_scan == SCAN_SINGLE && w_scanKey == r_cand) begin
            w_cntNext = w_cntInc;
            if (w_cntInc == 4'(DEBOUNCE_SCANS)) begin
              w_stateNext = ST_PRESSED;
              w_cntNext   = 4'd0;
              w_accept    = 1'b1;
            end
          end else begin
            w_stateNext = ST_IDLE;
            w_cntNext   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (w_scan == SCAN_NONE) begin
            w_stateNext = ST_RELEASE;
            w_cntNext   = 4'd1;
          end
        end
        ST_RELEASE: begin
          if (w_scan == SCAN_NONE) begin
            w_cntNext = w_cntInc;
            if (w_cntInc == 4'(DEBOUNCE_SCANS)) begin
              w_stateNext = ST_IDLE;
              w_cntNext   = 4'd0;
            end
          end else begin
            w_stateNext = ST_PRESSED;
            w_cntNext   = 4'd0;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_cntNext   = 4'd0;
        end
      endcase
    end
  end

  // A clear coinciding with an acceptance keeps only the newly accepted code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keyCode  <= 4'd0;
      r_keyValid <= 1'b0;
      r_value    <= 16'h0000;
    end else begin
      r_keyValid <= w_accept;
      if (w_accept) r_keyCode <= r_cand;
      if (clear) begin
        r_value <= w_accept ? {12'h000, r_cand} : 16'h0000;
      end else if (w_accept) begin
        r_value <= {r_value[11:0], r_cand};
      end
    end
  end

  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;
  assign key_held  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);
  assign value     = r_value;

endmodule

// File: tb/tb_keypad_scanner4x4.sv
// Directed bench for keypad_scanner4x4 with a key-matrix model and a queue of
// expected key_valid pulses (code and value) checked whenever a pulse appears.
module tb_keypad_scanner4x4;

  localparam int SDB  = 2;
  localparam int DS   = 3;
  localparam int SCAN = 16;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] value;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  logic [15:0] keysDown = 16'h0000;
  logic [15:0] modelValue = 16'h0000;
  pulse_t      expQ[$];
  int          errors = 0;
  int          checks = 0;
  int          pulseCount = 0;
  int          expPulses = 0;

  keypad_scanner4x4 #(.SCAN_DIV_BITS(SDB), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .value(value)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key shorts its row to its column while that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keysDown[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic clr);
    keysDown = keys;
    clear    = clr;
  endtask

  task automatic expectPress(input logic [3:0] code);
    pulse_t e;
    modelValue = {modelValue[11:0], code};
    e.code  = code;
    e.value = modelValue;
    expQ.push_back(e);
    expPulses++;
  endtask

  // Every cycle goes through here so any key_valid pulse is matched against the queue.
  task automatic tick();
    pulse_t e;
    @(posedge clk);
    #1;
    if (key_valid) begin
      pulseCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {15'h0, key_valid}, 16'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_code", {12'h0, key_code}, {12'h0, e.code});
        checkOutput("pulse_value", value, e.value);
        checkOutput("pulse_held", {15'h0, key_held}, 16'd1);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic waitScanStart();
    logic [3:0] prev;
    logic       found;
    prev  = col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = col;
    end
    checkOutput("scan_start", {15'h0, found}, 16'd1);
  endtask

  task automatic pressAndRelease(input logic [3:0] code);
    expectPress(code);
    applyStimulus(16'h0001 << code, 1'b0);
    ticks(5 * SCAN);
    applyStimulus(16'h0000, 1'b0);
    ticks(5 * SCAN);
  endtask

  initial begin
    logic [3:0] expCol;

    // Reset state and column sequence
    #23;
    checkOutput("rst_col", {12'h0, col}, 16'h000E);
    checkOutput("rst_code", {12'h0, key_code}, 16'h0000);
    checkOutput("rst_valid", {15'h0, key_valid}, 16'h0000);
    checkOutput("rst_held", {15'h0, key_held}, 16'h0000);
    checkOutput("rst_value", value, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("col_after_release", {12'h0, col}, 16'h000E);
    for (int k = 1; k <= 32; k++) begin
      tick();
      expCol = ~(4'b0001 << ((k / 4) % 4));
      checkOutput("col_seq", {12'h0, col}, {12'h0, expCol});
    end

    // Single press of (1,2), exact acceptance timing, hold and release
    waitScanStart();
    applyStimulus(16'h0040, 1'b0);
    expectPress(4'h6);
    ticks(47);
    checkOutput("pre_accept_valid", {15'h0, key_valid}, 16'd0);
    checkOutput("pre_accept_held", {15'h0, key_held}, 16'd0);
    tick();
    checkOutput("accept_valid", {15'h0, key_valid}, 16'd1);
    checkOutput("accept_code", {12'h0, key_code}, 16'h0006);
    checkOutput("accept_value", value, 16'h0006);
    checkOutput("accept_held", {15'h0, key_held}, 16'd1);
    tick();
    checkOutput("valid_one_cycle", {15'h0, key_valid}, 16'd0);
    ticks(10 * SCAN);
    checkOutput("hold_no_repeat", 16'(pulseCount), 16'(expPulses));
    waitScanStart();
    applyStimulus(16'h0000, 1'b0);
    ticks(47);
    checkOutput("release_still_held", {15'h0, key_held}, 16'd1);
    tick();
    checkOutput("release_held_low", {15'h0, key_held}, 16'd0);

    // Bounce on (0,1): pressed on alternate scans
    waitScanStart();
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i % 2 == 0) ? 16'h0002 : 16'h0000, 1'b0);
      ticks(SCAN);
      checkOutput("bounce_held", {15'h0, key_held}, 16'd0);
    end
    applyStimulus(16'h0000, 1'b0);
    ticks(2 * SCAN);
    checkOutput("bounce_pulses", 16'(pulseCount), 16'(expPulses));

    // Entry sequence 1..5 then clear
    for (int code = 1; code <= 5; code++) pressAndRelease(4'(code));
    checkOutput("entry_pulses", 16'(pulseCount), 16'(expPulses));
    checkOutput("entry_value", value, 16'h2345);
    applyStimulus(16'h0000, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0);
    modelValue = 16'h0000;
    checkOutput("clear_value", value, 16'h0000);

    // Two keys together from IDLE, then a second key while one is held
    applyStimulus(16'h0801, 1'b0);
    ticks(6 * SCAN);
    checkOutput("ghost_pulses", 16'(pulseCount), 16'(expPulses));
    checkOutput("ghost_held", {15'h0, key_held}, 16'd0);
    applyStimulus(16'h0000, 1'b0);
    ticks(5 * SCAN);
    expectPress(4'hF);
    applyStimulus(16'h8000, 1'b0);
    ticks(5 * SCAN);
    checkOutput("f_held", {15'h0, key_held}, 16'd1);
    applyStimulus(16'h8001, 1'b0);
    ticks(5 * SCAN);
    checkOutput("both_held", {15'h0, key_held}, 16'd1);
    applyStimulus(16'h0001, 1'b0);
    ticks(5 * SCAN);
    checkOutput("second_still_held", {15'h0, key_held}, 16'd1);
    applyStimulus(16'h0000, 1'b0);
    ticks(5 * SCAN);
    checkOutput("both_released", {15'h0, key_held}, 16'd0);
    checkOutput("conflict_pulses", 16'(pulseCount), 16'(expPulses));

    // Reset during DEBOUNCE
    waitScanStart();
    applyStimulus(16'h0020, 1'b0);
    ticks(24);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("rstdeb_col", {12'h0, col}, 16'h000E);
    checkOutput("rstdeb_value", value, 16'h0000);
    checkOutput("rstdeb_code", {12'h0, key_code}, 16'h0000);
    applyStimulus(16'h0000, 1'b0);
    modelValue = 16'h0000;
    #10;
    rst_n = 1'b1;
    ticks(5 * SCAN);
    checkOutput("rstdeb_pulses", 16'(pulseCount), 16'(expPulses));

    // Reset during PRESSED
    expectPress(4'h7);
    applyStimulus(16'h0080, 1'b0);
    ticks(5 * SCAN);
    checkOutput("rstpr_held_before", {15'h0, key_held}, 16'd1);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("rstpr_held", {15'h0, key_held}, 16'd0);
    checkOutput("rstpr_value", value, 16'h0000);
    checkOutput("rstpr_code", {12'h0, key_code}, 16'h0000);
    checkOutput("rstpr_col", {12'h0, col}, 16'h000E);
    applyStimulus(16'h0000, 1'b0);
    modelValue = 16'h0000;
    #10;
    rst_n = 1'b1;
    ticks(5 * SCAN);
    checkOutput("rstpr_pulses", 16'(pulseCount), 16'(expPulses));

    // Clear on the acceptance cycle of 0xA, with 0x0003 already entered
    pressAndRelease(4'h3);
    checkOutput("pre_collision_value", value, 16'h0003);
    waitScanStart();
    applyStimulus(16'h0400, 1'b0);
    modelValue = 16'h0000;
    expectPress(4'hA);
    ticks(47);
    applyStimulus(16'h0400, 1'b1);
    tick();
    applyStimulus(16'h0400, 1'b0);
    checkOutput("collision_value", value, 16'h000A);
    checkOutput("collision_code", {12'h0, key_code}, 16'h000A);
    applyStimulus(16'h0000, 1'b0);
    ticks(5 * SCAN);

    checkOutput("final_pulses", 16'(pulseCount), 16'(expPulses));
    checkOutput("queue_empty", 16'(expQ.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
